raster_dispatch_ctrl: RTL and testbench

Sequences triangle descriptors from triangle setup into the single rasterizer backend.
- Buffers descriptors in a small FIFO.
- Issues one triangle at a time using the backend's ready/i_dv/done protocol.
- Tags the frame's last triangle and reports frame completion to the frame-buffer swap logic.
- Sits between triangle setup and the rasterizer backend in the render pipeline.

---
 rtl/raster_pkg.sv | 40 ++++
 rtl/raster_dispatch_fifo.sv | 58 +++++
 rtl/raster_dispatch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_raster_dispatch_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types for the raster dispatch path: triangle descriptor layout, FIFO entry and
// dispatch FSM encoding.
package raster_pkg;

  localparam int unsigned DATAWIDTH = 12;
  localparam int unsigned IDWIDTH   = 16;

  typedef struct packed {
    logic [1:0][DATAWIDTH-1:0]   bb_tl;
    logic [1:0][DATAWIDTH-1:0]   bb_br;
    logic [2*DATAWIDTH-1:0]      edge_val0;
    logic [2*DATAWIDTH-1:0]      edge_val1;
    logic [2*DATAWIDTH-1:0]      edge_val2;
    logic [1:0][2*DATAWIDTH-1:0] edge_delta0;
    logic [1:0][2*DATAWIDTH-1:0] edge_delta1;
    logic [1:0][2*DATAWIDTH-1:0] edge_delta2;
    logic [DATAWIDTH-1:0]        z;
    logic [1:0][DATAWIDTH-1:0]   z_delta;
    logic [IDWIDTH-1:0]          id;
  } tri_desc_t;

  typedef struct packed {
    tri_desc_t desc;
    logic      last;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    DispIdle  = 2'd0,
    DispIssue = 2'd1,
    DispWait  = 2'd2,
    DispFlush = 2'd3
  } disp_state_e;

  // Bounding box with bottom-right above/left of top-left covers no pixels.
  function automatic logic bb_inverted(input tri_desc_t d);
    return ($signed(d.bb_br[0]) < $signed(d.bb_tl[0])) ||
           ($signed(d.bb_br[1]) < $signed(d.bb_tl[1]));
  endfunction

endpackage

// File: rtl/raster_dispatch_fifo.sv
// Synchronous descriptor FIFO with wrap-bit pointers and a combinational head read.
module raster_dispatch_fifo
  import raster_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  fifo_entry_t wr_entry,
  input  logic        pop,
  output fifo_entry_t rd_entry,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [AddrW:0] PtrOne = 1;

  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  fifo_entry_t    mem_q [FIFO_DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign rd_entry = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: rtl/raster_dispatch_ctrl.sv
// Buffers setup descriptors and issues them one at a time to the rasterizer backend,
// reporting frame completion. Define RASTER_DISPATCH_CULL_EN to drop empty-bbox triangles.
module raster_dispatch_ctrl
  import raster_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = raster_pkg::DATAWIDTH,
  parameter int unsigned IDWIDTH    = raster_pkg::IDWIDTH,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNTWIDTH   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                frame_start,
  input  tri_desc_t           s_tri,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output tri_desc_t           m_tri,
  output logic                m_dv,
  output logic                m_last,
  input  logic                be_ready,
  input  logic                be_done,
  output logic                frame_done,
  output logic                busy,
`ifdef RASTER_DISPATCH_CULL_EN
  output logic [CNTWIDTH-1:0] cull_count,
`endif
  output logic [CNTWIDTH-1:0] tri_count
);

  localparam logic [1:0] StIdle  = DispIdle;
  localparam logic [1:0] StIssue = DispIssue;
  localparam logic [1:0] StWait  = DispWait;
  localparam logic [1:0] StFlush = DispFlush;

  localparam logic [CNTWIDTH-1:0] CntOne = 1;

  // Descriptor layout is fixed by the package; a mismatched build never accepts work.
  localparam bit LayoutOk = (DATAWIDTH == raster_pkg::DATAWIDTH) &&
                            (IDWIDTH == raster_pkg::IDWIDTH) &&
                            (FIFO_DEPTH >= 2) &&
                            ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  logic [1:0]          state_q, state_d;
  logic                last_seen_q, last_seen_d;
  logic                last_issued_q, last_issued_d;
  logic [CNTWIDTH-1:0] tri_count_q, tri_count_d;

  fifo_entry_t wr_entry, head;
  logic        fifo_full, fifo_empty, fifo_push;
  logic        accept, issue, intake_open;

  assign intake_open = (state_q == StIssue) || (state_q == StWait);
  assign s_ready     = LayoutOk && intake_open && !fifo_full && !last_seen_q;
  assign accept      = s_valid && s_ready;

  assign m_dv   = (state_q == StIssue) && !fifo_empty;
  assign issue  = m_dv && be_ready;
  assign m_tri  = head.desc;
  assign m_last = m_dv && head.last;

  assign frame_done = (state_q == StFlush);
  assign busy       = (state_q != StIdle);
  assign tri_count  = tri_count_q;

  assign wr_entry = '{desc: s_tri, last: s_last};

`ifdef RASTER_DISPATCH_CULL_EN
  logic                cull;
  logic [CNTWIDTH-1:0] cull_count_q, cull_count_d;

  // Culled descriptors are still handshaked so setup never stalls on them.
  assign cull       = !s_last && bb_inverted(s_tri);
  assign fifo_push  = accept && !cull;
  assign cull_count = cull_count_q;

  always_comb begin
    cull_count_d = cull_count_q;
    if ((state_q == StIdle) && frame_start) begin
      cull_count_d = '0;
    end else if (accept && cull && (cull_count_q != '1)) begin
      cull_count_d = cull_count_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cull_count_q <= '0;
    end else begin
      cull_count_q <= cull_count_d;
    end
  end
`else
  assign fifo_push = accept;
`endif

  raster_dispatch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (fifo_push),
    .wr_entry (wr_entry),
    .pop      (issue),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    last_seen_d   = last_seen_q;
    last_issued_d = last_issued_q;
    tri_count_d   = tri_count_q;

    case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d       = StIssue;
          tri_count_d   = '0;
          last_seen_d   = 1'b0;
          last_issued_d = 1'b0;
        end
      end
      StIssue: begin
        if (issue) begin
          state_d       = StWait;
          last_issued_d = head.last;
          if (tri_count_q != '1) begin
            tri_count_d = tri_count_q + CntOne;
          end
        end
      end
      StWait: begin
        if (be_done) begin
          state_d = last_issued_q ? StFlush : StIssue;
        end
      end
      StFlush: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept && s_last) begin
      last_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      last_seen_q   <= 1'b0;
      last_issued_q <= 1'b0;
      tri_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_seen_q   <= last_seen_d;
      last_issued_q <= last_issued_d;
      tri_count_q   <= tri_count_d;
    end
  end

endmodule

// File: tb/tb_raster_dispatch_ctrl.sv
// Directed bench for raster_dispatch_ctrl: stimulus queues expected issues, a monitor
// pops and compares them as the backend accepts each triangle.
module tb_raster_dispatch_ctrl;
  import raster_pkg::*;

  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            frame_start = 1'b0;
  tri_desc_t       s_tri = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  tri_desc_t       m_tri;
  logic            m_dv;
  logic            m_last;
  logic            be_ready = 1'b0;
  logic            be_done_model = 1'b0;
  logic            be_done_force = 1'b0;
  logic            frame_done;
  logic            busy;
  logic [CntW-1:0] tri_count;
`ifdef RASTER_DISPATCH_CULL_EN
  logic [CntW-1:0] cull_count;
`endif

  typedef struct {
    tri_desc_t desc;
    logic      last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   done_delay = 3;

  always #5 clk = ~clk;

  raster_dispatch_ctrl #(
    .FIFO_DEPTH (8),
    .CNTWIDTH   (CntW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .s_tri       (s_tri),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_tri       (m_tri),
    .m_dv        (m_dv),
    .m_last      (m_last),
    .be_ready    (be_ready),
    .be_done     (be_done_model | be_done_force),
    .frame_done  (frame_done),
    .busy        (busy),
`ifdef RASTER_DISPATCH_CULL_EN
    .cull_count  (cull_count),
`endif
    .tri_count   (tri_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_desc(input string name, input tri_desc_t act, input tri_desc_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got id %0h desc %0h, expected id %0h desc %0h",
               name, act.id, act, exp.id, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  function automatic tri_desc_t make_desc(input logic [15:0] id);
    tri_desc_t d;
    d = '0;
    d.id          = id;
    d.bb_tl[0]    = 12'(id);
    d.bb_tl[1]    = 12'(id + 16'd1);
    d.bb_br[0]    = 12'(id + 16'd5);
    d.bb_br[1]    = 12'(id + 16'd7);
    d.edge_val0   = 24'h5a5a00 ^ 24'(id);
    d.edge_val1   = 24'h3c3c00 ^ 24'(id);
    d.edge_val2   = 24'h0f0f00 ^ 24'(id);
    d.edge_delta0 = {24'h111000 ^ 24'(id), 24'h222000 ^ 24'(id)};
    d.edge_delta1 = {24'h333000 ^ 24'(id), 24'h444000 ^ 24'(id)};
    d.edge_delta2 = {24'h555000 ^ 24'(id), 24'h666000 ^ 24'(id)};
    d.z           = 12'h800 ^ 12'(id);
    d.z_delta     = {12'h0a0 ^ 12'(id), 12'h050 ^ 12'(id)};
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // keep: the descriptor is expected to reach the backend.
  task automatic push_tri(input tri_desc_t d, input logic last, input bit keep);
    int n;
    s_tri   = d;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 300);
    if (!s_ready) begin
      fail_bound("push_accept");
    end else if (keep) begin
      exp_q.push_back('{desc: d, last: last});
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_frame_done(input string name, input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < max);
    if (!frame_done) begin
      fail_bound(name);
    end else begin
      @(negedge clk);
      check({name, "_pulse_width"}, 32'(frame_done), 32'd0);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
    end
    step();
  endtask

  // Backend model: raises be_done done_delay cycles after each issue.
  initial begin : backend
    bit fire;
    int cnt;
    cnt = -1;
    forever begin
      @(negedge clk);
      fire = rstn && m_dv && be_ready;
      step();
      be_done_model = 1'b0;
      if (!rstn) begin
        cnt = -1;
      end else if (fire) begin
        cnt = done_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          be_done_model = 1'b1;
          cnt = -1;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && m_dv && be_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got id %0h, expected no issue", m_tri.id);
        end else begin
          e = exp_q.pop_front();
          check_desc("issue_desc", m_tri, e.desc);
          check("issue_last", 32'(m_last), 32'(e.last));
        end
      end
      if (rstn && frame_done) begin
        done_seen++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  done_before;
    bit  any_hit;
    bit  all_busy;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_dv", 32'(m_dv), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tri_count", 32'(tri_count), 32'd0);
    rstn = 1'b1;
    step();

    // Single-triangle frame; s_valid alongside frame_start is not accepted
    be_ready    = 1'b1;
    done_delay  = 5;
    done_before = done_seen;
    s_tri       = make_desc(16'd1);
    s_last      = 1'b1;
    s_valid     = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    check("t1_ready_in_idle", 32'(s_ready), 32'd0);
    step();
    frame_start = 1'b0;
    push_tri(make_desc(16'd1), 1'b1, 1'b1);
    @(negedge clk);
    check("t1_latency_m_dv", 32'(m_dv), 32'd1);
    check("t1_latency_m_last", 32'(m_last), 32'd1);
    step();
    wait_frame_done("t1_frame_done", 100);
    check("t1_tri_count", 32'(tri_count), 32'd1);
    check("t1_done_count", 32'(done_seen - done_before), 32'd1);
    repeat (3) step();
    check("t1_count_holds", 32'(tri_count), 32'd1);

    // Backpressure: eight fill the FIFO, the ninth waits for a pop plus one cycle
    be_ready   = 1'b0;
    done_delay = 2;
    open_frame();
    for (int i = 0; i < 8; i++) begin
      push_tri(make_desc(16'(i)), 1'b0, 1'b1);
    end
    s_tri    = make_desc(16'd8);
    s_last   = 1'b0;
    s_valid  = 1'b1;
    be_ready = 1'b1;
    @(negedge clk);
    check("t2_full_no_push_through", 32'(s_ready), 32'd0);
    step();
    push_tri(make_desc(16'd8), 1'b0, 1'b1);
    push_tri(make_desc(16'd9), 1'b1, 1'b1);
    wait_frame_done("t2_frame_done", 500);
    check("t2_tri_count", 32'(tri_count), 32'd10);
    check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

    // Open frame with an empty FIFO; stray be_done outside WAIT is ignored
    be_ready    = 1'b1;
    done_before = done_seen;
    open_frame();
    any_hit  = 1'b0;
    all_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      be_done_force = (i == 10);
      @(negedge clk);
      any_hit  = any_hit | m_dv;
      all_busy = all_busy & busy;
      step();
    end
    be_done_force = 1'b0;
    check("t3_m_dv_idle", 32'(any_hit), 32'd0);
    check("t3_busy_held", 32'(all_busy), 32'd1);
    check("t3_no_frame_done", 32'(done_seen - done_before), 32'd0);
    push_tri(make_desc(16'd30), 1'b1, 1'b1);
    wait_frame_done("t3_frame_done", 100);
    check("t3_tri_count", 32'(tri_count), 32'd1);

    // Post-last refusal
    be_ready    = 1'b0;
    done_before = done_seen;
    open_frame();
    push_tri(make_desc(16'd20), 1'b0, 1'b1);
    push_tri(make_desc(16'd21), 1'b0, 1'b1);
    push_tri(make_desc(16'd22), 1'b1, 1'b1);
    s_tri   = make_desc(16'd23);
    s_last  = 1'b0;
    s_valid = 1'b1;
    any_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      any_hit = any_hit | s_ready;
      step();
    end
    s_valid  = 1'b0;
    check("t4_refused_after_last", 32'(any_hit), 32'd0);
    be_ready = 1'b1;
    wait_frame_done("t4_frame_done", 200);
    repeat (5) step();
    check("t4_done_once", 32'(done_seen - done_before), 32'd1);
    check("t4_tri_count", 32'(tri_count), 32'd3);
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-flight with four descriptors queued behind an in-flight triangle
    be_ready   = 1'b1;
    done_delay = 1000;
    open_frame();
    for (int i = 0; i < 5; i++) begin
      push_tri(make_desc(16'(40 + i)), 1'b0, 1'b1);
    end
    check("t5_one_in_flight", 32'(tri_count), 32'd1);
    open_frame();
    check("t5_frame_start_ignored", 32'(tri_count), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("t5_rst_s_ready", 32'(s_ready), 32'd0);
    check("t5_rst_m_dv", 32'(m_dv), 32'd0);
    check("t5_rst_m_last", 32'(m_last), 32'd0);
    check("t5_rst_frame_done", 32'(frame_done), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_tri_count", 32'(tri_count), 32'd0);
    exp_q.delete();
    repeat (2) step();
    rstn       = 1'b1;
    done_delay = 3;
    step();
    open_frame();
    @(negedge clk);
    check("t5_fifo_empty_m_dv", 32'(m_dv), 32'd0);
    check("t5_ready_after_reset", 32'(s_ready), 32'd1);
    step();
    push_tri(make_desc(16'd50), 1'b1, 1'b1);
    wait_frame_done("t5_frame_done", 100);
    check("t5_tri_count", 32'(tri_count), 32'd1);

`ifdef RASTER_DISPATCH_CULL_EN
    // Inverted bbox x-range is culled; the last descriptor always goes through
    begin
      tri_desc_t d;
      be_ready   = 1'b1;
      done_delay = 2;
      open_frame();
      d          = make_desc(16'd60);
      d.bb_tl[0] = 12'd10;
      d.bb_tl[1] = 12'd10;
      d.bb_br[0] = 12'd5;
      d.bb_br[1] = 12'd20;
      push_tri(d, 1'b0, 1'b0);
      push_tri(make_desc(16'd61), 1'b1, 1'b1);
      wait_frame_done("t6_frame_done", 100);
      check("t6_tri_count", 32'(tri_count), 32'd1);
      check("t6_cull_count", 32'(cull_count), 32'd1);
    end
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
